// File: rtl/rf_dump_reader.sv
// ============================================================================
// Module      : rf_dump_reader
// Description : Walks an RF address range through the read port and streams
//               {address, data} beats on a valid/ready interface.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_dump_reader #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              Start,
  input  logic              Abort,
  input  logic [ADDR_W-1:0] StartAddr,
  input  logic [ADDR_W-1:0] EndAddr,
  output logic [ADDR_W-1:0] RsAddr,
  input  logic [DATA_W-1:0] RsData,
  output logic              DumpValid,
  input  logic              DumpReady,
  output logic [ADDR_W-1:0] DumpAddr,
  output logic [DATA_W-1:0] DumpData,
  output logic              DumpLast,
  output logic              Busy,
  output logic              Done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] r_end;
  logic              r_dumpValid;
  logic [ADDR_W-1:0] r_dumpAddr;
  logic [DATA_W-1:0] r_dumpData;
  logic              r_dumpLast;
  logic              r_done;

  logic w_load;
  logic w_accept;

  // The output register refills whenever it is empty or being drained this cycle.
  assign w_load   = (r_state == S_RUN) && (!r_dumpValid || DumpReady);
  assign w_accept = r_dumpValid && DumpReady;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_end       <= '0;
      r_dumpValid <= 1'b0;
      r_dumpAddr  <= '0;
      r_dumpData  <= '0;
      r_dumpLast  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_end   <= EndAddr;
            r_ptr   <= StartAddr;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (Abort) begin
            r_state     <= S_IDLE;
            r_dumpValid <= 1'b0;
            r_dumpLast  <= 1'b0;
          end else if (w_load) begin
            r_dumpData  <= RsData;
            r_dumpAddr  <= r_ptr;
            r_dumpLast  <= (r_ptr == r_end);
            r_dumpValid <= 1'b1;
            r_ptr       <= r_ptr + ADDR_W'(1);
            if (r_ptr == r_end) begin
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (Abort) begin
            r_state     <= S_IDLE;
            r_dumpValid <= 1'b0;
            r_dumpLast  <= 1'b0;
          end else if (w_accept) begin
            r_state     <= S_IDLE;
            r_dumpValid <= 1'b0;
            r_dumpLast  <= 1'b0;
            r_done      <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign RsAddr    = r_ptr;
  assign DumpValid = r_dumpValid;
  assign DumpAddr  = r_dumpAddr;
  assign DumpData  = r_dumpData;
  assign DumpLast  = r_dumpLast;
  assign Done      = r_done;
  assign Busy      = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_rf_dump_reader.sv
// ============================================================================
// Module      : tb_rf_dump_reader
// Description : Directed self-checking bench for rf_dump_reader with an RF model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rf_dump_reader;

  logic        clk;
  logic        rst_n;
  logic        Start;
  logic        Abort;
  logic [4:0]  StartAddr;
  logic [4:0]  EndAddr;
  logic [4:0]  RsAddr;
  logic [31:0] RsData;
  logic        DumpValid;
  logic        DumpReady;
  logic [4:0]  DumpAddr;
  logic [31:0] DumpData;
  logic        DumpLast;
  logic        Busy;
  logic        Done;

  logic        regWrite;
  logic [4:0]  rdAddr;
  logic [31:0] rdData;
  logic [31:0] rf   [32];
  logic [31:0] gold [32];

  int checks;
  int failures;

  int          beatAddr [$];
  logic [31:0] beatData [$];
  logic        beatLast [$];
  int doneCnt, doneCyc, firstValidCyc, lastBeatCyc, stallErr;

  rf_dump_reader #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .Start     (Start),
    .Abort     (Abort),
    .StartAddr (StartAddr),
    .EndAddr   (EndAddr),
    .RsAddr    (RsAddr),
    .RsData    (RsData),
    .DumpValid (DumpValid),
    .DumpReady (DumpReady),
    .DumpAddr  (DumpAddr),
    .DumpData  (DumpData),
    .DumpLast  (DumpLast),
    .Busy      (Busy),
    .Done      (Done)
  );

  // RF model: combinational read, write on the rising edge.
  assign RsData = rf[RsAddr];
  always @(posedge clk) begin
    if (regWrite) rf[rdAddr] <= rdData;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic checkEq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Pulses Start and records every accepted beat. Cycle numbers count from the
  // Start cycle (T = 0).
  task automatic runDump(input logic [4:0] sa, input logic [4:0] ea, input int readyMode,
                         input int wrCyc, input logic [4:0] wrA, input logic [31:0] wrD,
                         input int reStartCyc, input int maxCyc);
    logic        pv, pr, pl;
    logic [4:0]  pa;
    logic [31:0] pd;
    beatAddr.delete();
    beatData.delete();
    beatLast.delete();
    doneCnt = 0; doneCyc = -1; firstValidCyc = -1; lastBeatCyc = -1; stallErr = 0;
    pv = 1'b0; pr = 1'b0; pl = 1'b0; pa = '0; pd = '0;
    @(negedge clk);
    Start = 1'b1; StartAddr = sa; EndAddr = ea; DumpReady = 1'b1;
    for (int cyc = 1; cyc <= maxCyc; cyc++) begin
      @(negedge clk);
      Start = (cyc == reStartCyc);
      if (cyc == reStartCyc) begin
        StartAddr = 5'd20;
        EndAddr   = 5'd25;
      end
      regWrite  = (cyc == wrCyc);
      rdAddr    = wrA;
      rdData    = wrD;
      DumpReady = (readyMode == 0) ? 1'b1 : ((cyc % 3) == 1);
      if (pv && !pr && !(DumpValid && DumpAddr == pa && DumpData == pd && DumpLast == pl))
        stallErr++;
      if (DumpValid && firstValidCyc < 0) firstValidCyc = cyc;
      if (DumpValid && DumpReady) begin
        beatAddr.push_back(int'(DumpAddr));
        beatData.push_back(DumpData);
        beatLast.push_back(DumpLast);
        if (DumpLast) lastBeatCyc = cyc;
      end
      if (Done) begin
        doneCnt++;
        if (doneCyc < 0) doneCyc = cyc;
      end
      pv = DumpValid; pr = DumpReady; pa = DumpAddr; pd = DumpData; pl = DumpLast;
      if (doneCyc >= 0 && cyc >= doneCyc + 2) break;
    end
    Start = 1'b0;
    regWrite = 1'b0;
  endtask

  task automatic verifyBeats(input string tag, input int sa, input int n);
    int a;
    checkEq({tag, " count"}, beatAddr.size(), n);
    for (int i = 0; i < n; i++) begin
      a = (sa + i) % 32;
      if (i < beatAddr.size()) begin
        checkEq({tag, " addr"}, beatAddr[i], a);
        checkEq({tag, " data"}, beatData[i], gold[a]);
        checkEq({tag, " last"}, beatLast[i], (i == n - 1));
      end
    end
    checkEq({tag, " doneCnt"}, doneCnt, 1);
    checkEq({tag, " stall"}, stallErr, 0);
  endtask

  task automatic checkIdleZero(input string tag);
    checkEq({tag, " valid"}, DumpValid, 0);
    checkEq({tag, " addr"}, DumpAddr, 0);
    checkEq({tag, " data"}, DumpData, 0);
    checkEq({tag, " last"}, DumpLast, 0);
    checkEq({tag, " busy"}, Busy, 0);
    checkEq({tag, " done"}, Done, 0);
    checkEq({tag, " rsaddr"}, RsAddr, 0);
  endtask

  initial begin
    int seen;
    checks = 0; failures = 0;
    for (int i = 0; i < 32; i++) begin
      rf[i]   = i * 32'h0101_0101;
      gold[i] = i * 32'h0101_0101;
    end
    regWrite = 1'b0; rdAddr = '0; rdData = '0;
    Abort = 1'b0; DumpReady = 1'b1; StartAddr = '0; EndAddr = 5'd31;

    // 1: reset dominates Start
    rst_n = 1'b0; Start = 1'b1;
    repeat (2) @(negedge clk);
    checkIdleZero("t1 reset");
    rst_n = 1'b1; Start = 1'b0;
    @(negedge clk);
    checkIdleZero("t1 post");

    // 2: full 32-word dump with ready held high
    runDump(5'd0, 5'd31, 0, -1, 5'd0, 32'd0, -1, 60);
    verifyBeats("t2", 0, 32);
    checkEq("t2 firstValid", firstValidCyc, 2);
    checkEq("t2 lastBeat", lastBeatCyc, 33);
    checkEq("t2 doneCyc", doneCyc, 34);

    // 3: wrapping range under back-pressure
    runDump(5'd30, 5'd1, 1, -1, 5'd0, 32'd0, -1, 60);
    verifyBeats("t3", 30, 4);

    // 4: write in the load cycle is not seen; a later dump sees it
    runDump(5'd5, 5'd5, 0, 1, 5'd5, 32'hF0F0_0F0F, -1, 20);
    verifyBeats("t4a", 5, 1);
    checkEq("t4a old data", (beatData.size() > 0) ? beatData[0] : 32'hx, 32'h0505_0505);
    gold[5] = 32'hF0F0_0F0F;
    runDump(5'd5, 5'd5, 0, -1, 5'd0, 32'd0, -1, 20);
    verifyBeats("t4b", 5, 1);

    // 5: abort on the third beat, then a single-word dump
    @(negedge clk);
    Start = 1'b1; StartAddr = 5'd0; EndAddr = 5'd31; DumpReady = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    repeat (3) @(negedge clk);
    checkEq("t5 beat3 valid", DumpValid, 1);
    checkEq("t5 beat3 addr", DumpAddr, 2);
    Abort = 1'b1;
    @(negedge clk);
    Abort = 1'b0;
    checkEq("t5 abort valid", DumpValid, 0);
    checkEq("t5 abort busy", Busy, 0);
    checkEq("t5 abort last", DumpLast, 0);
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (Done) seen++;
      @(negedge clk);
    end
    checkEq("t5 no done", seen, 0);
    runDump(5'd17, 5'd17, 0, -1, 5'd0, 32'd0, -1, 20);
    verifyBeats("t5", 17, 1);

    // 6a: Start while busy is ignored
    runDump(5'd8, 5'd11, 0, -1, 5'd0, 32'd0, 3, 30);
    verifyBeats("t6", 8, 4);
    checkEq("t6 doneCyc", doneCyc, 6);

    // 6b: reset mid-dump
    @(negedge clk);
    Start = 1'b1; StartAddr = 5'd0; EndAddr = 5'd31; DumpReady = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    repeat (3) @(negedge clk);
    checkEq("t6 busy pre-reset", Busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    checkIdleZero("t6 reset");
    rst_n = 1'b1;
    @(negedge clk);
    checkIdleZero("t6 post");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
